// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared state encoding and constants for the ISA cycle engines
package isa_pkg;

  localparam int ISA_AW = 23;
  localparam int ISA_DW = 16;
  localparam logic [15:0] TIMEOUT_DATA = 16'hFFFF;

  typedef enum logic [2:0] {IDLE, ADDR, SETUP, CMD, WAIT, HOLD} isa_state_t;

endpackage

// File: rtl/isa_phase_tick.sv
// rtl/isa_phase_tick.sv - ISA phase divider producing a one-clk tick per phase
module isa_phase_tick
  import isa_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int W = $clog2(CLK_DIV);
  localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);

  logic [W-1:0] div;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) div <= '0;
    else if (div == LAST) div <= '0;
    else div <= div + W'(1);
  end

  assign tick = (div == LAST);

endmodule

// File: rtl/isa_cycle_arbiter.sv
// rtl/isa_cycle_arbiter.sv - two-port round-robin ISA memory cycle sequencer
module isa_cycle_arbiter
  import isa_pkg::*;
#(
  parameter int AW      = ISA_AW,
  parameter int DW      = ISA_DW,
  parameter int CLK_DIV = 4,
  parameter int MIN_CMD = 3,
  parameter int TIMEOUT = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [1:0]    req_valid,
  input  logic [1:0]    req_we,
  input  logic [2*AW-1:0] req_addr,
  input  logic [2*DW-1:0] req_wdata,
  output logic [1:0]    gnt,
  output logic [1:0]    done,
  output logic          err,
  output logic [DW-1:0] rdata,
  output logic [AW-1:0] isa_addr,
  output logic [DW-1:0] isa_wdata,
  output logic          isa_data_oe,
  input  logic [DW-1:0] isa_rdata,
  output logic          bale,
  output logic          mem_r_n,
  output logic          mem_w_n,
  input  logic          io_chrdy
);

  localparam logic [2:0] CMD_LAST  = 3'(MIN_CMD - 1);
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  isa_state_t state;
  logic       rr;
  logic       owner;
  logic       we;
  logic       err_pending;
  logic [2:0] pcnt;
  logic [7:0] wcnt;
  logic       tick;

  logic          win;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;

  isa_phase_tick #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(state == IDLE),
    .tick (tick)
  );

  // Contention goes to the port that did not win the last contended arbitration.
  assign win       = (req_valid == 2'b11) ? ~rr : req_valid[1];
  assign sel_addr  = win ? req_addr[2*AW-1:AW]   : req_addr[AW-1:0];
  assign sel_wdata = win ? req_wdata[2*DW-1:DW]  : req_wdata[DW-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      rr          <= 1'b0;
      owner       <= 1'b0;
      we          <= 1'b0;
      err_pending <= 1'b0;
      pcnt        <= '0;
      wcnt        <= '0;
      gnt         <= '0;
      done        <= '0;
      err         <= 1'b0;
      rdata       <= '0;
      isa_addr    <= '0;
      isa_wdata   <= '0;
      isa_data_oe <= 1'b0;
      bale        <= 1'b0;
      mem_r_n     <= 1'b1;
      mem_w_n     <= 1'b1;
    end else begin
      gnt  <= '0;
      done <= '0;
      err  <= 1'b0;
      unique case (state)
        IDLE: if (|req_valid) begin
          state       <= ADDR;
          gnt         <= win ? 2'b10 : 2'b01;
          owner       <= win;
          we          <= req_we[win];
          isa_addr    <= sel_addr;
          isa_wdata   <= sel_wdata;
          isa_data_oe <= req_we[win];
          bale        <= 1'b1;
          pcnt        <= '0;
          wcnt        <= '0;
          err_pending <= 1'b0;
          if (&req_valid) rr <= win;
        end
        ADDR: if (tick) begin
          state <= SETUP;
          bale  <= 1'b0;
        end
        SETUP: if (tick) begin
          state   <= CMD;
          mem_r_n <= we;
          mem_w_n <= ~we;
        end
        CMD: if (tick) begin
          if (pcnt == CMD_LAST) begin
            if (io_chrdy) begin
              state   <= HOLD;
              mem_r_n <= 1'b1;
              mem_w_n <= 1'b1;
              rdata   <= isa_rdata;
            end else begin
              state <= WAIT;
            end
          end else begin
            pcnt <= pcnt + 3'd1;
          end
        end
        WAIT: if (tick) begin
          if (io_chrdy) begin
            state   <= HOLD;
            mem_r_n <= 1'b1;
            mem_w_n <= 1'b1;
            rdata   <= isa_rdata;
          end else if (wcnt == WAIT_LAST) begin
            state       <= HOLD;
            mem_r_n     <= 1'b1;
            mem_w_n     <= 1'b1;
            err_pending <= 1'b1;
            rdata       <= DW'(TIMEOUT_DATA);
          end else begin
            wcnt <= wcnt + 8'd1;
          end
        end
        HOLD: if (tick) begin
          state       <= IDLE;
          done        <= owner ? 2'b10 : 2'b01;
          err         <= err_pending;
          isa_data_oe <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_isa_cycle_arbiter.sv
// tb/tb_isa_cycle_arbiter.sv - self-checking bench for isa_cycle_arbiter
module tb_isa_cycle_arbiter;

  typedef struct {
    int          port;
    logic        we;
    logic [22:0] addr;
    logic [15:0] wdata;
    logic [15:0] rd;
    int          nwait;
    bit          stuck;
    bit          drop;
    int          exp_done;
    logic [15:0] exp_rdata;
    bit          exp_err;
    int          exp_cmd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_valid;
  logic [1:0]  req_we;
  logic [45:0] req_addr;
  logic [31:0] req_wdata;
  logic [1:0]  gnt;
  logic [1:0]  done;
  logic        err;
  logic [15:0] rdata;
  logic [22:0] isa_addr;
  logic [15:0] isa_wdata;
  logic        isa_data_oe;
  logic [15:0] isa_rdata;
  logic        bale;
  logic        mem_r_n;
  logic        mem_w_n;
  logic        io_chrdy;

  always #5 clk = ~clk;

  isa_cycle_arbiter dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .gnt(gnt), .done(done),
    .err(err), .rdata(rdata), .isa_addr(isa_addr), .isa_wdata(isa_wdata),
    .isa_data_oe(isa_data_oe), .isa_rdata(isa_rdata), .bale(bale),
    .mem_r_n(mem_r_n), .mem_w_n(mem_w_n), .io_chrdy(io_chrdy)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rr_m  = 0;
  vec_t tbl[6];
  vec_t c[2];
  vec_t rv[2];
  int exp_order[4] = '{1, 0, 1, 0};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; io_chrdy = 1'b1;
    tick1(); tick1();
    rst_n = 1'b1; rr_m = 0;
  endtask

  task automatic launch(input vec_t v);
    req_valid[v.port]           = 1'b1;
    req_we[v.port]              = v.we;
    req_addr[v.port*23 +: 23]   = v.addr;
    req_wdata[v.port*16 +: 16]  = v.wdata;
  endtask

  // Edge k counts clocks after the grant edge; done is expected at k = 24 + 4*wait phases.
  task automatic serve(input vec_t v);
    int gap, k, nb, nr, nw, no, bad;
    bit got;
    io_chrdy  = !v.stuck && (v.nwait == 0);
    isa_rdata = v.rd;
    gap = 0;
    do begin tick1(); gap++; end while (gnt == 2'b00 && gap < 20);
    check("gnt_gap", gap, 1);
    check("gnt_port", gnt, 32'(1) << v.port);
    if (gnt == 2'b00) return;
    if (v.drop) req_valid[v.port] = 1'b0;
    k = 0; nb = 0; nr = 0; nw = 0; no = 0; bad = 0; got = 0;
    while (k <= 400) begin
      if (bale) nb++;
      if (!mem_r_n) nr++;
      if (!mem_w_n) nw++;
      if (isa_data_oe) no++;
      if (!mem_r_n && !mem_w_n) bad++;
      if (bale && (!mem_r_n || !mem_w_n)) bad++;
      if (k > 0 && gnt != 2'b00) bad++;
      if (done != 2'b00) begin got = 1; break; end
      if (!v.stuck && v.nwait > 0 && k == 20 + 4*(v.nwait-1)) io_chrdy = 1'b1;
      tick1();
      k++;
    end
    check("done_seen", got, 1);
    check("done_edge", k, v.exp_done);
    check("done_port", done, 32'(1) << v.port);
    check("err", err, v.exp_err);
    if (!v.we) check("rdata", rdata, v.exp_rdata);
    else check("isa_wdata", isa_wdata, v.wdata);
    check("isa_addr", isa_addr, v.addr);
    check("bale_clks", nb, 4);
    check("cmd_clks", v.we ? nw : nr, v.exp_cmd);
    check("other_cmd_clks", v.we ? nr : nw, 0);
    check("oe_clks", no, v.we ? v.exp_done : 0);
    check("oe_at_done", isa_data_oe, 0);
    check("invariants", bad, 0);
    req_valid[v.port] = 1'b0;
    io_chrdy = 1'b1;
  endtask

  function automatic vec_t mk_rand(input int p);
    vec_t v;
    v.port = p; v.we = 1'($urandom_range(0, 1));
    v.addr = 23'($urandom); v.wdata = 16'($urandom); v.rd = 16'($urandom);
    v.nwait = $urandom_range(0, 3); v.stuck = 0; v.drop = ($urandom_range(0, 3) == 0);
    v.exp_done = 24 + 4*v.nwait; v.exp_rdata = v.rd; v.exp_err = 0;
    v.exp_cmd = 4*(3 + v.nwait);
    return v;
  endfunction

  initial begin
    int ndone, p, w, mask;
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    isa_rdata = '0; io_chrdy = 1'b1; rst_n = 1'b0;

    tbl[0] = '{0, 1'b0, 23'h0D0000, 16'h0000, 16'hA55A, 0, 1'b0, 1'b0, 24,  16'hA55A, 1'b0, 12};
    tbl[1] = '{1, 1'b1, 23'h000300, 16'h1234, 16'h0000, 0, 1'b0, 1'b0, 24,  16'h0000, 1'b0, 12};
    tbl[2] = '{0, 1'b0, 23'h012345, 16'h0000, 16'hC3C3, 5, 1'b0, 1'b0, 44,  16'hC3C3, 1'b0, 32};
    tbl[3] = '{1, 1'b0, 23'h0D0002, 16'h0000, 16'hBEEF, 0, 1'b1, 1'b0, 280, 16'hFFFF, 1'b1, 268};
    tbl[4] = '{0, 1'b1, 23'h400000, 16'hFEDC, 16'h0000, 2, 1'b0, 1'b1, 32,  16'h0000, 1'b0, 20};
    tbl[5] = '{1, 1'b0, 23'h7FFFFF, 16'h0000, 16'h0F0F, 1, 1'b0, 1'b0, 28,  16'h0F0F, 1'b0, 16};

    do_reset();
    check("rst_gnt", gnt, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_rdata", rdata, 0);
    check("rst_isa_addr", isa_addr, 0);
    check("rst_isa_wdata", isa_wdata, 0);
    check("rst_oe", isa_data_oe, 0);
    check("rst_bale", bale, 0);
    check("rst_mem_r_n", mem_r_n, 1);
    check("rst_mem_w_n", mem_w_n, 1);

    for (int i = 0; i < 6; i++) begin
      launch(tbl[i]);
      serve(tbl[i]);
      tick1();
    end

    // Both ports requesting continuously from rr = 0: grants go 1,0,1,0.
    do_reset();
    c[0] = '{0, 1'b0, 23'h001000, 16'h0000, 16'h1111, 0, 1'b0, 1'b0, 24, 16'h1111, 1'b0, 12};
    c[1] = '{1, 1'b1, 23'h002000, 16'h2222, 16'h0000, 0, 1'b0, 1'b0, 24, 16'h0000, 1'b0, 12};
    launch(c[0]);
    launch(c[1]);
    for (int i = 0; i < 4; i++) begin
      serve(c[exp_order[i]]);
      if (i < 3) launch(c[exp_order[i]]);
      else req_valid = '0;
    end
    tick1();

    // Reset while the cycle is stretched in WAIT.
    do_reset();
    launch(tbl[0]);
    io_chrdy = 1'b0;
    repeat (26) tick1();
    check("wait_mem_r_n", mem_r_n, 0);
    rst_n = 1'b0; req_valid = '0;
    tick1();
    check("midrst_mem_r_n", mem_r_n, 1);
    check("midrst_bale", bale, 0);
    check("midrst_oe", isa_data_oe, 0);
    check("midrst_done", done, 0);
    rst_n = 1'b1; io_chrdy = 1'b1; rr_m = 0;
    ndone = 0;
    repeat (40) begin tick1(); if (done != 2'b00) ndone++; end
    check("no_done_after_rst", ndone, 0);
    launch(tbl[0]);
    serve(tbl[0]);
    tick1();

    do_reset();
    for (int r = 0; r < 20; r++) begin
      mask = $urandom_range(1, 3);
      rv[0] = mk_rand(0);
      rv[1] = mk_rand(1);
      if (mask == 3) begin
        launch(rv[0]);
        launch(rv[1]);
        w = 1 - rr_m;
        rr_m = w;
        serve(rv[w]);
        serve(rv[1-w]);
      end else begin
        p = (mask == 2) ? 1 : 0;
        launch(rv[p]);
        serve(rv[p]);
      end
      tick1();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
